// File: rtl/dense_pkg.sv
// Shared definitions for the dense-layer transmit path: widths, issuer FSM
// states and the bundle layout handed to the delay pipeline.
package dense_pkg;

  localparam int unsigned SIZE            = 3;
  localparam int unsigned DATA_SIZE       = 16;
  localparam int unsigned ACT_TYPE_SIZE   = 4;
  localparam int unsigned COST_TYPE_SIZE  = 8;
  localparam int unsigned DENSE_TYPE_SIZE = 4;
  localparam int unsigned VEC_W           = SIZE * DATA_SIZE;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } issuer_state_t;

  typedef struct packed {
    logic [ACT_TYPE_SIZE-1:0]   act_type;
    logic                       backprop_cost;
    logic [COST_TYPE_SIZE-1:0]  cost_type;
    logic                       is_update;
    logic                       is_cost_layer;
    logic [DENSE_TYPE_SIZE-1:0] dense_type;
    logic [VEC_W-1:0]           predict_value;
    logic [31:0]                layer_index;
    logic [31:0]                row_index;
    logic [VEC_W-1:0]           x;
    logic [VEC_W-1:0]           w;
  } dense_bundle_t;

endpackage

// File: rtl/dense_row_issuer_if.sv
// Command, weight-memory read and bundle-issue signals of dense_row_issuer.
// The issuer connects through master; the controller/memory/pipeline side through slave.
interface dense_row_issuer_if
  import dense_pkg::*;
#(
  parameter int size            = SIZE,
  parameter int data_size       = DATA_SIZE,
  parameter int cost_type_size  = COST_TYPE_SIZE,
  parameter int dense_type_size = DENSE_TYPE_SIZE,
  parameter int act_type_size   = ACT_TYPE_SIZE
);

  logic                          start;
  logic [act_type_size-1:0]      cfg_act_type;
  logic                          cfg_backprop_cost;
  logic [cost_type_size-1:0]     cfg_cost_type;
  logic                          cfg_is_update;
  logic                          cfg_is_cost_layer;
  logic [dense_type_size-1:0]    cfg_dense_type;
  logic [data_size*size-1:0]     cfg_predict_value;
  logic [data_size*size-1:0]     cfg_x;
  logic [31:0]                   cfg_layer_index;
  logic [31:0]                   cfg_row_count;
  logic                          stall;

  logic                          w_rd_en;
  logic [31:0]                   w_rd_layer;
  logic [31:0]                   w_rd_row;
  logic [data_size*size-1:0]     w_rd_data;

  logic                          busy;
  logic                          done;
  logic                          issue_valid;
  logic                          issue_last;
  logic [act_type_size-1:0]      act_type;
  logic                          backprop_cost;
  logic [cost_type_size-1:0]     cost_type;
  logic                          is_update;
  logic                          is_cost_layer;
  logic [dense_type_size-1:0]    dense_type;
  logic [data_size*size-1:0]     predict_value;
  logic [data_size*size-1:0]     x;
  logic [31:0]                   w_layer_index;
  logic [31:0]                   w_row_index;
  logic [data_size*size-1:0]     w;

  modport master (
    input  start, cfg_act_type, cfg_backprop_cost, cfg_cost_type, cfg_is_update,
           cfg_is_cost_layer, cfg_dense_type, cfg_predict_value, cfg_x,
           cfg_layer_index, cfg_row_count, stall, w_rd_data,
    output w_rd_en, w_rd_layer, w_rd_row, busy, done, issue_valid, issue_last,
           act_type, backprop_cost, cost_type, is_update, is_cost_layer, dense_type,
           predict_value, x, w_layer_index, w_row_index, w
  );

  modport slave (
    output start, cfg_act_type, cfg_backprop_cost, cfg_cost_type, cfg_is_update,
           cfg_is_cost_layer, cfg_dense_type, cfg_predict_value, cfg_x,
           cfg_layer_index, cfg_row_count, stall, w_rd_data,
    input  w_rd_en, w_rd_layer, w_rd_row, busy, done, issue_valid, issue_last,
           act_type, backprop_cost, cost_type, is_update, is_cost_layer, dense_type,
           predict_value, x, w_layer_index, w_row_index, w
  );

endinterface

// File: rtl/dense_row_issuer.sv
// Walks the weight rows of one dense layer, reads each row from weight memory
// and issues one fully populated bundle per row into the delay pipeline.
module dense_row_issuer
  import dense_pkg::*;
#(
  parameter int size            = SIZE,
  parameter int data_size       = DATA_SIZE,
  parameter int cost_type_size  = COST_TYPE_SIZE,
  parameter int dense_type_size = DENSE_TYPE_SIZE,
  parameter int act_type_size   = ACT_TYPE_SIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  dense_row_issuer_if.master bus
);

  localparam int VW = data_size * size;

  issuer_state_t state_q, state_d;

  logic                       cmd_load;
  logic                       rd_en;
  logic [31:0]                rd_row_q;
  logic [31:0]                row_count_q;
  logic [31:0]                layer_q;
  logic [act_type_size-1:0]   act_type_q;
  logic                       backprop_cost_q;
  logic [cost_type_size-1:0]  cost_type_q;
  logic                       is_update_q;
  logic                       is_cost_layer_q;
  logic [dense_type_size-1:0] dense_type_q;
  logic [VW-1:0]              predict_value_q;
  logic [VW-1:0]              x_q;

  logic                       issue_valid_q;
  logic                       issue_last_q;
  logic [31:0]                w_row_q;
  logic [VW-1:0]              w_q;

  always_comb begin
    state_d  = state_q;
    cmd_load = 1'b0;
    rd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          cmd_load = 1'b1;
          state_d  = (bus.cfg_row_count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (!bus.stall && (rd_row_q < row_count_q)) begin
          rd_en = 1'b1;
          if (rd_row_q == row_count_q - 32'd1) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_row_q        <= '0;
      row_count_q     <= '0;
      layer_q         <= '0;
      act_type_q      <= '0;
      backprop_cost_q <= 1'b0;
      cost_type_q     <= '0;
      is_update_q     <= 1'b0;
      is_cost_layer_q <= 1'b0;
      dense_type_q    <= '0;
      predict_value_q <= '0;
      x_q             <= '0;
    end else if (cmd_load) begin
      rd_row_q        <= '0;
      row_count_q     <= bus.cfg_row_count;
      layer_q         <= bus.cfg_layer_index;
      act_type_q      <= bus.cfg_act_type;
      backprop_cost_q <= bus.cfg_backprop_cost;
      cost_type_q     <= bus.cfg_cost_type;
      is_update_q     <= bus.cfg_is_update;
      is_cost_layer_q <= bus.cfg_is_cost_layer;
      dense_type_q    <= bus.cfg_dense_type;
      predict_value_q <= bus.cfg_predict_value;
      x_q             <= bus.cfg_x;
    end else if (rd_en) begin
      rd_row_q <= rd_row_q + 32'd1;
    end
  end

  // Read-return stage: the row index travels alongside the read so the issued
  // bundle carries the index of the data it holds, regardless of later stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_last_q  <= 1'b0;
      w_row_q       <= '0;
      w_q           <= '0;
    end else begin
      issue_valid_q <= rd_en;
      issue_last_q  <= rd_en && (rd_row_q == row_count_q - 32'd1);
      if (rd_en) begin
        w_row_q <= rd_row_q;
        w_q     <= bus.w_rd_data;
      end
    end
  end

  assign bus.w_rd_en       = rd_en;
  assign bus.w_rd_layer    = layer_q;
  assign bus.w_rd_row      = rd_row_q;
  assign bus.busy          = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done          = (state_q == DONE);
  assign bus.issue_valid   = issue_valid_q;
  assign bus.issue_last    = issue_last_q;
  assign bus.act_type      = act_type_q;
  assign bus.backprop_cost = backprop_cost_q;
  assign bus.cost_type     = cost_type_q;
  assign bus.is_update     = is_update_q;
  assign bus.is_cost_layer = is_cost_layer_q;
  assign bus.dense_type    = dense_type_q;
  assign bus.predict_value = predict_value_q;
  assign bus.x             = x_q;
  assign bus.w_layer_index = layer_q;
  assign bus.w_row_index   = w_row_q;
  assign bus.w             = w_q;

endmodule

// File: tb/tb_dense_row_issuer.sv
// Randomized bench for dense_row_issuer: expected read/issue/done cycles are
// derived from the command's row count and the stall trace alone.
module tb_dense_row_issuer;
  import dense_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dense_row_issuer_if #(
    .size(SIZE), .data_size(DATA_SIZE), .cost_type_size(COST_TYPE_SIZE),
    .dense_type_size(DENSE_TYPE_SIZE), .act_type_size(ACT_TYPE_SIZE)
  ) bus ();

  dense_row_issuer #(
    .size(SIZE), .data_size(DATA_SIZE), .cost_type_size(COST_TYPE_SIZE),
    .dense_type_size(DENSE_TYPE_SIZE), .act_type_size(ACT_TYPE_SIZE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic logic [VEC_W-1:0] mem_word(input logic [31:0] layer, input logic [31:0] row);
    logic [DATA_SIZE-1:0] e;
    e = 16'(row + 32'd1) ^ {layer[7:0], 8'h00};
    return {SIZE{e}};
  endfunction

  // Weight memory: data for the addressed row while a read is requested, junk otherwise.
  assign bus.w_rd_data = bus.w_rd_en ? mem_word(bus.w_rd_layer, bus.w_rd_row) : 48'h0BAD_F00D_DEAD;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic dense_bundle_t rand_cmd();
    dense_bundle_t c;
    c.act_type      = 4'($urandom);
    c.backprop_cost = 1'($urandom);
    c.cost_type     = 8'($urandom);
    c.is_update     = 1'($urandom);
    c.is_cost_layer = 1'($urandom);
    c.dense_type    = 4'($urandom);
    c.predict_value = 48'({$urandom, $urandom});
    c.layer_index   = $urandom;
    c.row_index     = '0;
    c.x             = 48'({$urandom, $urandom});
    c.w             = '0;
    return c;
  endfunction

  task automatic drive_cfg(input dense_bundle_t c, input logic [31:0] rows);
    bus.cfg_act_type      = c.act_type;
    bus.cfg_backprop_cost = c.backprop_cost;
    bus.cfg_cost_type     = c.cost_type;
    bus.cfg_is_update     = c.is_update;
    bus.cfg_is_cost_layer = c.is_cost_layer;
    bus.cfg_dense_type    = c.dense_type;
    bus.cfg_predict_value = c.predict_value;
    bus.cfg_x             = c.x;
    bus.cfg_layer_index   = c.layer_index;
    bus.cfg_row_count     = rows;
  endtask

  task automatic check_fields(input string tag, input dense_bundle_t c);
    check({tag, ".act_type"},      64'(bus.act_type),      64'(c.act_type));
    check({tag, ".backprop_cost"}, 64'(bus.backprop_cost), 64'(c.backprop_cost));
    check({tag, ".cost_type"},     64'(bus.cost_type),     64'(c.cost_type));
    check({tag, ".is_update"},     64'(bus.is_update),     64'(c.is_update));
    check({tag, ".is_cost_layer"}, 64'(bus.is_cost_layer), 64'(c.is_cost_layer));
    check({tag, ".dense_type"},    64'(bus.dense_type),    64'(c.dense_type));
    check({tag, ".predict_value"}, 64'(bus.predict_value), 64'(c.predict_value));
    check({tag, ".x"},             64'(bus.x),             64'(c.x));
    check({tag, ".w_layer_index"}, 64'(bus.w_layer_index), 64'(c.layer_index));
  endtask

  task automatic check_zero(input string tag);
    dense_bundle_t z;
    z = '0;
    check({tag, ".w_rd_en"},     64'(bus.w_rd_en),     64'd0);
    check({tag, ".w_rd_layer"},  64'(bus.w_rd_layer),  64'd0);
    check({tag, ".w_rd_row"},    64'(bus.w_rd_row),    64'd0);
    check({tag, ".busy"},        64'(bus.busy),        64'd0);
    check({tag, ".done"},        64'(bus.done),        64'd0);
    check({tag, ".issue_valid"}, 64'(bus.issue_valid), 64'd0);
    check({tag, ".issue_last"},  64'(bus.issue_last),  64'd0);
    check({tag, ".w_row_index"}, 64'(bus.w_row_index), 64'd0);
    check({tag, ".w"},           64'(bus.w),           64'd0);
    check_fields(tag, z);
  endtask

  // stall_mode: 0 none, 1 random, 2 single stall in cycle 3.
  task automatic run_cmd(input string tag, input int unsigned n, input logic [31:0] layer,
                         input int unsigned stall_mode, input bit inj_run, input bit inj_done);
    dense_bundle_t c, alt;
    bit            st[128];
    int unsigned   rc[$];
    int unsigned   done_c, i;
    bit            exp_rd, exp_iss;
    int unsigned   rd_r, is_r;

    c = rand_cmd();
    c.layer_index = layer;
    for (int j = 0; j < 128; j++) begin
      st[j] = (stall_mode == 1 && j < 60) ? ($urandom_range(0, 2) == 0) : 1'b0;
    end
    if (stall_mode == 2) st[3] = 1'b1;
    i = 1;
    while (rc.size() < n) begin
      if (!st[i]) rc.push_back(i);
      i++;
    end
    done_c = (n == 0) ? 1 : rc[n-1] + 2;

    @(negedge clk);
    drive_cfg(c, n);
    bus.start = 1'b1;
    bus.stall = st[0];
    #1;
    check({tag, ".c0_busy"}, 64'(bus.busy), 64'd0);

    for (int unsigned k = 1; k <= done_c + 1; k++) begin
      @(negedge clk);
      alt = rand_cmd();
      drive_cfg(alt, $urandom_range(1, 9));
      bus.start = ((inj_run && k == 2 && k < done_c) || (inj_done && k == done_c));
      bus.stall = st[k];
      #1;
      exp_rd  = 1'b0;
      exp_iss = 1'b0;
      rd_r    = 0;
      is_r    = 0;
      foreach (rc[r]) begin
        if (rc[r] == k)     begin exp_rd  = 1'b1; rd_r = r; end
        if (rc[r] + 1 == k) begin exp_iss = 1'b1; is_r = r; end
      end
      check({tag, ".busy"},        64'(bus.busy),        64'(k < done_c && n != 0));
      check({tag, ".done"},        64'(bus.done),        64'(k == done_c));
      check({tag, ".w_rd_en"},     64'(bus.w_rd_en),     64'(exp_rd));
      check({tag, ".issue_valid"}, 64'(bus.issue_valid), 64'(exp_iss));
      if (exp_rd) begin
        check({tag, ".w_rd_row"},   64'(bus.w_rd_row),   64'(rd_r));
        check({tag, ".w_rd_layer"}, 64'(bus.w_rd_layer), 64'(layer));
      end
      if (exp_iss) begin
        check({tag, ".w_row_index"}, 64'(bus.w_row_index), 64'(is_r));
        check({tag, ".w"},           64'(bus.w),           64'(mem_word(layer, is_r)));
        check({tag, ".issue_last"},  64'(bus.issue_last),  64'(is_r == n - 1));
      end else begin
        check({tag, ".issue_last"},  64'(bus.issue_last),  64'd0);
      end
      if (k >= done_c) check_fields({tag, ".fields"}, c);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    dense_bundle_t c;

    // Reset with busy-looking inputs
    rst_n = 1'b0;
    c = rand_cmd();
    drive_cfg(c, 7);
    bus.start = 1'b1;
    bus.stall = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle.busy",    64'(bus.busy),        64'd0);
      check("idle.done",    64'(bus.done),        64'd0);
      check("idle.valid",   64'(bus.issue_valid), 64'd0);
      check("idle.w_rd_en", 64'(bus.w_rd_en),     64'd0);
    end
    check_zero("idle_end");

    run_cmd("basic",     4, 32'd2,    0, 1'b0, 1'b0);
    run_cmd("stall",     3, $urandom, 2, 1'b0, 1'b0);
    run_cmd("zero",      0, $urandom, 0, 1'b0, 1'b0);
    run_cmd("ign_run",   4, $urandom, 0, 1'b1, 1'b0);
    run_cmd("ign_done",  2, $urandom, 0, 1'b0, 1'b1);
    run_cmd("one",       1, $urandom, 1, 1'b1, 1'b1);
    for (int t = 0; t < 12; t++) begin
      run_cmd("rand", $urandom_range(0, 9), $urandom, 1, 1'($urandom), 1'($urandom));
    end

    // Abort a 5-row command at cycle 3
    c = rand_cmd();
    @(negedge clk);
    drive_cfg(c, 5);
    bus.start = 1'b1;
    bus.stall = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (k == 3) rst_n = 1'b0;
      #1;
      if (k < 3) check("abort.pre_row", 64'(bus.w_rd_row), 64'(k - 1));
    end
    check_zero("abort");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort.done", 64'(bus.done), 64'd0);
      check("abort.busy", 64'(bus.busy), 64'd0);
    end
    rst_n = 1'b1;
    run_cmd("post_abort", 3, $urandom, 1, 1'b0, 1'b0);

    // Maximum row count: counter and last-row compare at the top of the range
    c = rand_cmd();
    @(negedge clk);
    drive_cfg(c, 32'hFFFF_FFFF);
    bus.start = 1'b1;
    bus.stall = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      #1;
      check("big.busy",     64'(bus.busy),       64'd1);
      check("big.w_rd_en",  64'(bus.w_rd_en),    64'd1);
      check("big.w_rd_row", 64'(bus.w_rd_row),   64'(k - 1));
      check("big.last",     64'(bus.issue_last), 64'd0);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("big_abort");
    rst_n = 1'b1;
    run_cmd("final", 2, $urandom, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
